// File: rtl/cnn_pkg.sv
// Shared constants and the FSM state type for the feature-map streaming blocks.
package cnn_pkg;
  localparam int BITSIZE = 14;
  localparam int LANES   = 16;
  localparam int MAX_ROW = 112;
  localparam int SIZE_W  = $clog2(MAX_ROW + 1);
  localparam int GRP_W   = 6;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_WAIT_ACK = 2'd3
  } fsm_state_t;

  // A zero-sized dimension is treated as one.
  function automatic logic [SIZE_W-1:0] size_or_one(input logic [SIZE_W-1:0] s);
    return (s == '0) ? SIZE_W'(1) : s;
  endfunction
endpackage

// File: rtl/rd_valid_pipe.sv
// Tracks SRAM reads in flight: a DEPTH-deep valid/last shift register with async clear.
module rd_valid_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_last,
  output logic out_valid,
  output logic out_last,
  output logic any_valid
);
  logic [DEPTH-1:0] valid_sr;
  logic [DEPTH-1:0] last_sr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_sr <= '0;
      last_sr  <= '0;
    end else begin
      valid_sr[0] <= in_valid;
      last_sr[0]  <= in_valid & in_last;
      for (int i = 1; i < DEPTH; i++) begin
        valid_sr[i] <= valid_sr[i-1];
        last_sr[i]  <= last_sr[i-1];
      end
    end
  end

  assign out_valid = valid_sr[DEPTH-1];
  assign out_last  = last_sr[DEPTH-1];
  assign any_valid = |valid_sr;
endmodule

// File: rtl/fmap_pixel_streamer.sv
// Streams a feature map from SRAM into the 3x3 window buffer, one 16-channel group at a time.
// Handshake: a read issues in any ISSUE cycle where fifo_ready is high; wr_en marks input_pixels valid.
module fmap_pixel_streamer
  import cnn_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [SIZE_W-1:0]        row_size,
  input  logic [SIZE_W-1:0]        col_size,
  input  logic [GRP_W-1:0]         ch_groups,
  output logic                     mem_rd_en,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [LANES*BITSIZE-1:0] mem_rd_data,
  input  logic                     fifo_ready,
  input  logic                     depth_window_done,
  output logic [LANES*BITSIZE-1:0] input_pixels,
  output logic                     wr_en,
  output logic                     busy,
  output logic                     group_done,
  output logic                     frame_done,
  output logic [1:0]               fsm_state
);
  fsm_state_t        state, state_next;
  logic [SIZE_W-1:0] row_size_q, col_size_q, col, row;
  logic [GRP_W-1:0]  ch_groups_q, grp;
  logic [ADDR_W-1:0] cur_addr;
  logic              issue, last_pix, last_grp;
  logic              pipe_valid, pipe_last, pipe_busy;

  assign issue    = (state == ST_ISSUE) && fifo_ready;
  assign last_pix = (row == col_size_q - SIZE_W'(1)) && (col == row_size_q - SIZE_W'(1));
  assign last_grp = (grp == ch_groups_q - GRP_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      row_size_q  <= '0;
      col_size_q  <= '0;
      ch_groups_q <= '0;
      col         <= '0;
      row         <= '0;
      grp         <= '0;
      cur_addr    <= '0;
      frame_done  <= 1'b0;
    end else begin
      state      <= state_next;
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          row_size_q  <= size_or_one(row_size);
          col_size_q  <= size_or_one(col_size);
          ch_groups_q <= (ch_groups == '0) ? GRP_W'(1) : ch_groups;
          cur_addr    <= base_addr;
          col         <= '0;
          row         <= '0;
          grp         <= '0;
        end
        ST_ISSUE: if (issue) begin
          // Groups are contiguous in SRAM, so the address simply keeps counting.
          cur_addr <= cur_addr + ADDR_W'(1);
          if (col == row_size_q - SIZE_W'(1)) begin
            col <= '0;
            row <= last_pix ? '0 : row + SIZE_W'(1);
          end else begin
            col <= col + SIZE_W'(1);
          end
        end
        ST_WAIT_ACK: if (depth_window_done) begin
          if (last_grp) frame_done <= 1'b1;
          else          grp        <= grp + GRP_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     if (start) state_next = ST_ISSUE;
      ST_ISSUE:    if (issue && last_pix) state_next = ST_DRAIN;
      ST_DRAIN:    if (!pipe_busy) state_next = ST_WAIT_ACK;
      ST_WAIT_ACK: if (depth_window_done) state_next = last_grp ? ST_IDLE : ST_ISSUE;
      default:     state_next = ST_IDLE;
    endcase
  end

  rd_valid_pipe #(.DEPTH(RD_LAT)) u_rd_valid_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (issue),
    .in_last   (last_pix),
    .out_valid (pipe_valid),
    .out_last  (pipe_last),
    .any_valid (pipe_busy)
  );

  assign mem_rd_en    = issue;
  assign mem_addr     = cur_addr;
  assign wr_en        = pipe_valid;
  assign group_done   = pipe_valid & pipe_last;
  assign input_pixels = pipe_valid ? mem_rd_data : '0;
  assign busy         = (state != ST_IDLE);
  assign fsm_state    = state;
endmodule

// File: tb/tb_fmap_pixel_streamer.sv
// Directed bench for fmap_pixel_streamer: one instance at RD_LAT=1, one at RD_LAT=3.
module tb_fmap_pixel_streamer;
  import cnn_pkg::*;
  localparam int PW = LANES * BITSIZE;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start1 = 1'b0, start3 = 1'b0;
  logic [15:0] base_addr = '0;
  logic [6:0]  row_size = '0, col_size = '0;
  logic [5:0]  ch_groups = '0;
  logic fifo_ready = 1'b1, depth_window_done = 1'b0;

  logic rd_en1, wr_en1, busy1, gd1, fd1, rd_en3, wr_en3, busy3, gd3, fd3;
  logic [15:0] addr1, addr3;
  logic [PW-1:0] rd_data1, rd_data3, pix1, pix3;
  logic [1:0] st1, st3;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic mon3 = 1'b0;

  logic [15:0] exp_q[$];
  logic [15:0] iss_a_q[$];
  int iss_c_q[$], wr_c_q[$], gd_c_q[$], fd_c_q[$], ack_c_q[$];
  logic [PW-1:0] wr_d_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fmap_pixel_streamer #(.ADDR_W(16), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .base_addr(base_addr), .row_size(row_size),
    .col_size(col_size), .ch_groups(ch_groups), .mem_rd_en(rd_en1), .mem_addr(addr1),
    .mem_rd_data(rd_data1), .fifo_ready(fifo_ready), .depth_window_done(depth_window_done),
    .input_pixels(pix1), .wr_en(wr_en1), .busy(busy1), .group_done(gd1), .frame_done(fd1),
    .fsm_state(st1));

  fmap_pixel_streamer #(.ADDR_W(16), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .base_addr(base_addr), .row_size(row_size),
    .col_size(col_size), .ch_groups(ch_groups), .mem_rd_en(rd_en3), .mem_addr(addr3),
    .mem_rd_data(rd_data3), .fifo_ready(fifo_ready), .depth_window_done(depth_window_done),
    .input_pixels(pix3), .wr_en(wr_en3), .busy(busy3), .group_done(gd3), .frame_done(fd3),
    .fsm_state(st3));

  // SRAM contents are a fixed function of the word address.
  function automatic logic [PW-1:0] pix_of(input logic [15:0] a);
    logic [PW-1:0] p;
    p = '0;
    for (int i = 0; i < LANES; i++) p[i*BITSIZE +: BITSIZE] = a[BITSIZE-1:0] ^ BITSIZE'(i * 37 + 5);
    return p;
  endfunction

  logic [15:0] a1_q;
  logic v1_q = 1'b0;
  logic [15:0] a3_q[3];
  logic [2:0] v3_q = '0;
  always @(posedge clk) begin
    a1_q <= addr1;
    v1_q <= rd_en1;
    a3_q[0] <= addr3;
    a3_q[1] <= a3_q[0];
    a3_q[2] <= a3_q[1];
    v3_q <= {v3_q[1:0], rd_en3};
  end
  assign rd_data1 = v1_q ? pix_of(a1_q) : '0;
  assign rd_data3 = v3_q[2] ? pix_of(a3_q[2]) : '0;

  wire m_rd = mon3 ? rd_en3 : rd_en1;
  wire m_wr = mon3 ? wr_en3 : wr_en1;
  wire m_gd = mon3 ? gd3 : gd1;
  wire m_fd = mon3 ? fd3 : fd1;
  wire [15:0] m_addr = mon3 ? addr3 : addr1;
  wire [PW-1:0] m_pix = mon3 ? pix3 : pix1;

  always @(negedge clk) begin
    if (m_rd) begin iss_a_q.push_back(m_addr); iss_c_q.push_back(cyc); end
    if (m_wr) begin wr_d_q.push_back(m_pix); wr_c_q.push_back(cyc); end
    if (m_gd) gd_c_q.push_back(cyc);
    if (m_fd) fd_c_q.push_back(cyc);
  end

  task automatic clear_q();
    iss_a_q.delete(); iss_c_q.delete(); wr_d_q.delete(); wr_c_q.delete();
    gd_c_q.delete(); fd_c_q.delete(); ack_c_q.delete(); exp_q.delete();
  endtask

  // Runs one frame, acking each group 3 cycles after its group_done is seen.
  // rel counts ISSUE-state cycles from 1; stalls and spurious pulses are keyed on rel.
  task automatic run_frame(input logic sel3, input logic [15:0] base, input logic [6:0] r,
                           input logic [6:0] c, input logic [5:0] g, input int st_lo, input int st_hi,
                           input int spur_start, input int spur_ack, output int t0);
    int n, rel, acks_sched, pend;
    clear_q();
    mon3 = sel3;
    base_addr = base; row_size = r; col_size = c; ch_groups = g;
    @(posedge clk); #1;
    if (sel3) start3 = 1'b1; else start1 = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start1 = 1'b0; start3 = 1'b0;
    n = 0; acks_sched = 0; pend = -1;
    while (fd_c_q.size() == 0 && n < 2000) begin
      rel = cyc - t0;
      fifo_ready = !(rel >= st_lo && rel <= st_hi);
      start1 = 1'b0;
      depth_window_done = 1'b0;
      if (rel == spur_start) begin row_size = 7'd2; start1 = 1'b1; end
      if (rel == spur_ack) depth_window_done = 1'b1;
      if (gd_c_q.size() > acks_sched && pend < 0) begin pend = cyc + 3; acks_sched++; end
      if (cyc == pend) begin depth_window_done = 1'b1; ack_c_q.push_back(cyc); pend = -1; end
      @(posedge clk); #1;
      n++;
    end
    depth_window_done = 1'b0; fifo_ready = 1'b1; start1 = 1'b0;
    checks++;
    if (n >= 2000) begin errors++; $display("FAIL frame_timeout got %0d cycles exp <2000", n); end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({rd_en1, wr_en1, busy1, gd1, fd1, st1} !== 7'd0) begin
      errors++; $display("FAIL reset_outputs got %b exp 0", {rd_en1, wr_en1, busy1, gd1, fd1, st1});
    end
    @(negedge clk) rst = 1'b1;
    clear_q(); mon3 = 1'b0;
    base_addr = 16'h0100; row_size = 7'd4; col_size = 7'd3; ch_groups = 6'd1;
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({rd_en1, busy1, wr_en1} !== 3'b111) begin
      errors++; $display("FAIL reset_pre_issue got %b exp 111", {rd_en1, busy1, wr_en1});
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({rd_en1, wr_en1, busy1, gd1, fd1, st1} !== 7'd0) begin
      errors++; $display("FAIL reset_mid_issue got %b exp 0", {rd_en1, wr_en1, busy1, gd1, fd1, st1});
    end
    checks++;
    if (addr1 !== 16'h0 || pix1 !== '0) begin
      errors++; $display("FAIL reset_addr_pix got addr %h exp 0000", addr1);
    end
    @(negedge clk) rst = 1'b1;
    clear_q();
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (wr_c_q.size() != 0 || iss_c_q.size() != 0) begin
      errors++; $display("FAIL reset_discard got wr %0d rd %0d exp 0 0", wr_c_q.size(), iss_c_q.size());
    end
    checks++;
    if (busy1 !== 1'b0 || st1 !== 2'd0) begin
      errors++; $display("FAIL reset_idle got busy %b state %0d exp 0 0", busy1, st1);
    end
  endtask

  task automatic test_stream();
    int t0;
    run_frame(1'b0, 16'h0100, 7'd4, 7'd3, 6'd1, -1, -1, -1, -1, t0);
    for (int i = 0; i < 12; i++) exp_q.push_back(16'h0100 + 16'(i));
    checks++;
    if (iss_a_q.size() != 12 || wr_d_q.size() != 12) begin
      errors++; $display("FAIL stream_count got rd %0d wr %0d exp 12 12", iss_a_q.size(), wr_d_q.size());
    end
    for (int i = 0; i < 12 && i < iss_a_q.size() && i < wr_d_q.size(); i++) begin
      checks++;
      if (iss_a_q[i] !== exp_q[i] || iss_c_q[i] != t0 + 1 + i || wr_c_q[i] != iss_c_q[i] + 1 ||
          wr_d_q[i] !== pix_of(exp_q[i])) begin
        errors++;
        $display("FAIL stream_beat[%0d] got addr %h cyc %0d wr_cyc %0d exp addr %h cyc %0d wr_cyc %0d",
                 i, iss_a_q[i], iss_c_q[i], wr_c_q[i], exp_q[i], t0 + 1 + i, t0 + 2 + i);
      end
    end
    checks++;
    if (gd_c_q.size() != 1 || wr_c_q.size() != 12 || gd_c_q[0] != wr_c_q[11]) begin
      errors++; $display("FAIL stream_group_done got %0d pulses exp 1 on last beat", gd_c_q.size());
    end
    checks++;
    if (fd_c_q.size() != 1 || ack_c_q.size() != 1 || fd_c_q[0] != ack_c_q[0] + 1) begin
      errors++; $display("FAIL stream_frame_done got %0d pulses exp 1 one cycle after ack", fd_c_q.size());
    end
    checks++;
    if (busy1 !== 1'b0) begin errors++; $display("FAIL stream_idle got busy %b exp 0", busy1); end
  endtask

  task automatic test_stall();
    int t0, in_stall;
    run_frame(1'b0, 16'h0100, 7'd4, 7'd3, 6'd1, 5, 7, -1, -1, t0);
    for (int i = 0; i < 12; i++) exp_q.push_back(16'h0100 + 16'(i));
    in_stall = 0;
    foreach (iss_c_q[i]) if (iss_c_q[i] >= t0 + 5 && iss_c_q[i] <= t0 + 7) in_stall++;
    checks++;
    if (in_stall != 0) begin errors++; $display("FAIL stall_issue got %0d exp 0", in_stall); end
    checks++;
    if (iss_a_q.size() != 12 || wr_d_q.size() != 12) begin
      errors++; $display("FAIL stall_count got rd %0d wr %0d exp 12 12", iss_a_q.size(), wr_d_q.size());
    end
    for (int i = 0; i < 12 && i < iss_a_q.size() && i < wr_d_q.size(); i++) begin
      checks++;
      if (iss_a_q[i] !== exp_q[i] || wr_d_q[i] !== pix_of(exp_q[i])) begin
        errors++; $display("FAIL stall_beat[%0d] got addr %h exp %h", i, iss_a_q[i], exp_q[i]);
      end
    end
    checks++;
    if (iss_c_q.size() != 12 || iss_c_q[11] != t0 + 15) begin
      errors++; $display("FAIL stall_last_issue got size %0d exp last at cycle %0d", iss_c_q.size(), t0 + 15);
    end
  endtask

  task automatic test_groups();
    int t0;
    run_frame(1'b0, 16'h0200, 7'd2, 7'd2, 6'd3, -1, -1, -1, -1, t0);
    for (int i = 0; i < 12; i++) exp_q.push_back(16'h0200 + 16'(i));
    checks++;
    if (iss_a_q.size() != 12 || gd_c_q.size() != 3 || ack_c_q.size() != 3) begin
      errors++; $display("FAIL groups_count got rd %0d gd %0d ack %0d exp 12 3 3",
                         iss_a_q.size(), gd_c_q.size(), ack_c_q.size());
    end
    for (int i = 0; i < 12 && i < iss_a_q.size() && i < wr_d_q.size(); i++) begin
      checks++;
      if (iss_a_q[i] !== exp_q[i] || wr_d_q[i] !== pix_of(exp_q[i])) begin
        errors++; $display("FAIL groups_beat[%0d] got addr %h exp %h", i, iss_a_q[i], exp_q[i]);
      end
    end
    if (iss_c_q.size() == 12 && ack_c_q.size() == 3) begin
      checks++;
      if (iss_c_q[4] != ack_c_q[0] + 1 || iss_c_q[8] != ack_c_q[1] + 1) begin
        errors++; $display("FAIL groups_restart got %0d %0d exp %0d %0d",
                           iss_c_q[4], iss_c_q[8], ack_c_q[0] + 1, ack_c_q[1] + 1);
      end
      checks++;
      if (fd_c_q.size() != 1 || fd_c_q[0] != ack_c_q[2] + 1) begin
        errors++; $display("FAIL groups_frame_done got %0d pulses exp 1 after third ack", fd_c_q.size());
      end
    end
  endtask

  task automatic test_wrap();
    int t0;
    run_frame(1'b1, 16'hFFF8, 7'd112, 7'd1, 6'd1, -1, -1, -1, -1, t0);
    for (int i = 0; i < 112; i++) exp_q.push_back(16'hFFF8 + 16'(i));
    checks++;
    if (iss_a_q.size() != 112 || wr_d_q.size() != 112) begin
      errors++; $display("FAIL wrap_count got rd %0d wr %0d exp 112 112", iss_a_q.size(), wr_d_q.size());
    end
    checks++;
    if (iss_a_q.size() > 8 && iss_a_q[8] !== 16'h0000) begin
      errors++; $display("FAIL wrap_zero got %h exp 0000", iss_a_q[8]);
    end
    for (int i = 0; i < 112 && i < iss_a_q.size() && i < wr_d_q.size(); i++) begin
      checks++;
      if (iss_a_q[i] !== exp_q[i] || wr_d_q[i] !== pix_of(exp_q[i]) || wr_c_q[i] != iss_c_q[i] + 3) begin
        errors++; $display("FAIL wrap_beat[%0d] got addr %h exp %h", i, iss_a_q[i], exp_q[i]);
      end
    end
    checks++;
    if (gd_c_q.size() != 1 || wr_c_q.size() != 112 || gd_c_q[0] != wr_c_q[111]) begin
      errors++; $display("FAIL wrap_group_done got %0d pulses exp 1", gd_c_q.size());
    end
  endtask

  task automatic test_ignore();
    int t0;
    run_frame(1'b0, 16'h0300, 7'd4, 7'd3, 6'd2, -1, -1, 3, 4, t0);
    for (int i = 0; i < 24; i++) exp_q.push_back(16'h0300 + 16'(i));
    checks++;
    if (iss_a_q.size() != 24 || wr_d_q.size() != 24) begin
      errors++; $display("FAIL ignore_count got rd %0d wr %0d exp 24 24", iss_a_q.size(), wr_d_q.size());
    end
    for (int i = 0; i < 24 && i < iss_a_q.size() && i < wr_d_q.size(); i++) begin
      checks++;
      if (iss_a_q[i] !== exp_q[i] || wr_d_q[i] !== pix_of(exp_q[i])) begin
        errors++; $display("FAIL ignore_beat[%0d] got addr %h exp %h", i, iss_a_q[i], exp_q[i]);
      end
    end
    checks++;
    if (gd_c_q.size() != 2 || ack_c_q.size() != 2 || fd_c_q.size() != 1 || fd_c_q[0] != ack_c_q[1] + 1) begin
      errors++; $display("FAIL ignore_pulses got gd %0d fd %0d exp 2 1", gd_c_q.size(), fd_c_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_groups();
    test_wrap();
    test_ignore();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
